multi_rate_counter: RTL
=======================

# multi_rate_counter

Parametrised successor to the single-digit display counter. It is a multi-digit up/down counter advanced by an internal programmable rate divider, with four selectable tick rates, synchronous clear, parallel load and a wrap indication. It sits between board switches and the hex-decoder bank; each 4-bit slice of `count_out` drives one `hex_decoder`.

## Interface
- `CLK_HZ`, default 50_000_000: input clock frequency in Hz.
- `BASE_HZ`, default 1: slowest tick rate in Hz. Constraint: `CLK_HZ % (4*BASE_HZ) == 0`.
- `DIGITS`, default 2: number of 4-bit digits; counter width `CW = 4*DIGITS`.
- `clock`, in, 1: single clock; all state is on its rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `enable`, in, 1: when low, both the divider and the counter hold.
- `rate_sel`, in, 2: tick rate select.
  - 0: every cycle.
  - 1: `4*BASE_HZ`.
  - 2: `2*BASE_HZ`.
  - 3: `BASE_HZ`.
- `up_down`, in, 1: direction; 1 counts up, 0 counts down.
- `clear`, in, 1: synchronous clear, active-high.
- `load`, in, 1: synchronous parallel load, active-high.
- `load_value`, in, CW: value to load.
- `count_out`, out, CW: registered count.
- `tick`, out, 1: one-cycle pulse, high in the cycle `count_out` shows a newly stepped value.
- `wrap`, out, 1: one-cycle pulse, high in the same cycle as a `tick` whose step wrapped the counter.

## Operation
- Divisor `D`, per `rate_sel`:
  - 0: `D = 1`
  - 1: `D = CLK_HZ/(4*BASE_HZ)`
  - 2: `D = CLK_HZ/(2*BASE_HZ)`
  - 3: `D = CLK_HZ/BASE_HZ`
- Divider register `div_cnt`, width `$clog2(CLK_HZ/BASE_HZ)`, minimum 1.
- Step condition: `step = enable & (div_cnt == 0) & ~rate_change`.
- Divider update on `step`: reload `D-1`.
- Divider update otherwise, when `enable` is high: decrement.
- `rate_change`: `rate_sel` differs from its value registered on the previous edge. When `rate_change` is high, `div_cnt` loads the new `D-1` and no step occurs.
- Priority per edge, highest first: `reset` > `clear` > `load` > `step` > hold.
  - `clear`: `count_out` ← 0, `div_cnt` ← `D-1`, `tick` and `wrap` low.
  - `load`: `count_out` ← `load_value` (masked per Configuration), `div_cnt` ← `D-1`, `tick` and `wrap` low.
  - `step`, up: `count_out` ← `count_out + 1`. Wrap when stepping from MAX to 0.
  - `step`, down: `count_out` ← `count_out − 1`. Wrap when stepping from 0 to MAX.
- MAX is `2^CW − 1` in hex mode and all digits = 9 in BCD mode.
- `enable` low: `div_cnt`, `count_out` held; `tick` and `wrap` forced low.
- `up_down` is sampled on the stepping edge only; changing it between steps does not disturb the divider.

## Timing
- Reset values: `count_out` = 0, `tick` = 0, `wrap` = 0, `div_cnt` = `D-1` for the `rate_sel` present at reset release, registered `rate_sel` = current `rate_sel`.
- Outputs are all registered; there is no combinational path from any input to any output.
- Steady state at divisor D: `tick` is high exactly 1 cycle in every D cycles.
- At `rate_sel` = 0: `tick` is high every cycle and the count moves every edge.
- First tick after reset release, `clear`, `load` or a rate change: D cycles after that edge.
- Mid-period `enable` low for N cycles delays the next tick by exactly N cycles.
- `load` and `clear` asserted together: `clear` wins.
- `reset` asserted mid-period: outputs drop immediately, without waiting for a clock edge.

## Configuration
- Macro: `MULTI_RATE_COUNTER_BCD_EN`.
- Defined: each digit counts 0–9.
  - Up carry: digit 9 → 0 increments the next digit.
  - Down borrow: digit 0 → 9 decrements the next digit.
  - `load_value` digits above 9 are loaded as 9.
  - `wrap` fires at 99…9 → 0 (up) and 0 → 99…9 (down).
- Undefined: plain binary count modulo `2^CW`; `load_value` is loaded unmodified.

## Test plan
All scenarios use `CLK_HZ`=16, `BASE_HZ`=1, `DIGITS`=2.
- Rate, hex mode: `rate_sel`=3, `up_down`=1, `enable`=1, 40 cycles after reset → `tick` at cycles 16 and 32; `count_out` = 0x02.
- Rate switch: hold `rate_sel`=0 for 5 cycles, then `rate_sel`=1 → `count_out` = 0x05; no tick on the switch edge; next tick 4 cycles later; thereafter one tick every 4 cycles.
- Wrap, hex mode: `load` 0xFE, `rate_sel`=0, up → `count_out` goes 0xFF, then 0x00 with `wrap`=1 in the same cycle as that tick. Then `up_down`=0 → `count_out` 0xFF with `wrap`=1.
- BCD mode: `load_value`=0x99, `rate_sel`=0, up → `count_out` 0x00 with `wrap`. `load_value`=0x1F → `count_out` 0x19. Count down from 0x10 → 0x09.
- Enable gating: `rate_sel`=2; drop `enable` for 3 cycles after cycle 4 → tick arrives at cycle 11 instead of 8; `tick` stays low while `enable` is low.
- Priority and reset: `clear`=`load`=1 → `count_out` 0. Assert `reset` mid-period → `count_out`, `tick` and `wrap` are 0 before the next edge. After release, first tick arrives D cycles later.

Source files
------------

// File: rtl/multi_rate_counter.sv
// Multi-digit up/down counter stepped by a programmable rate divider with four tick rates.
// Define MULTI_RATE_COUNTER_BCD_EN for per-digit BCD counting; the default is a plain binary count.
module multi_rate_counter #(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned BASE_HZ = 1,
    parameter int unsigned DIGITS  = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [1:0]            rate_sel,
    input  logic                  up_down,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   count_out,
    output logic                  tick,
    output logic                  wrap
);

    localparam int unsigned CW    = 4 * DIGITS;
    localparam int unsigned D_MAX = CLK_HZ / BASE_HZ;
    localparam int unsigned DIV_W = ($clog2(D_MAX) < 1) ? 1 : $clog2(D_MAX);

    localparam logic [DIV_W-1:0] RELOAD_0 = '0;
    localparam logic [DIV_W-1:0] RELOAD_1 = DIV_W'(CLK_HZ / (4 * BASE_HZ) - 1);
    localparam logic [DIV_W-1:0] RELOAD_2 = DIV_W'(CLK_HZ / (2 * BASE_HZ) - 1);
    localparam logic [DIV_W-1:0] RELOAD_3 = DIV_W'(D_MAX - 1);

    logic [CW-1:0]    r_count;
    logic             r_tick;
    logic             r_wrap;
    logic [DIV_W-1:0] r_div_cnt;
    logic [1:0]       r_rate_sel;

    logic [DIV_W-1:0] w_reload;
    logic             w_rate_change;
    logic             w_step;
    logic [CW-1:0]    w_count_inc;
    logic [CW-1:0]    w_count_dec;
    logic             w_carry_out;
    logic             w_borrow_out;
    logic [CW-1:0]    w_load_masked;

    // Divider reload value (D-1) for the currently selected rate
    always_comb begin
        w_reload = RELOAD_0;
        case (rate_sel)
            2'd0:    w_reload = RELOAD_0;
            2'd1:    w_reload = RELOAD_1;
            2'd2:    w_reload = RELOAD_2;
            default: w_reload = RELOAD_3;
        endcase
    end

    assign w_rate_change = (rate_sel != r_rate_sel);
    assign w_step        = enable & (r_div_cnt == '0) & ~w_rate_change;

`ifdef MULTI_RATE_COUNTER_BCD_EN
    // Ripple carry/borrow through the decimal digits; the chain's exit bit is the wrap
    always_comb begin
        logic       v_carry;
        logic       v_borrow;
        logic [3:0] v_digit;
        w_count_inc   = r_count;
        w_count_dec   = r_count;
        w_load_masked = load_value;
        v_carry       = 1'b1;
        v_borrow      = 1'b1;
        v_digit       = 4'd0;
        for (int d = 0; d < int'(DIGITS); d++) begin
            v_digit = r_count[4*d +: 4];
            if (v_carry) begin
                if (v_digit >= 4'd9) begin
                    w_count_inc[4*d +: 4] = 4'd0;
                end else begin
                    w_count_inc[4*d +: 4] = v_digit + 4'd1;
                    v_carry = 1'b0;
                end
            end
            if (v_borrow) begin
                if (v_digit == 4'd0) begin
                    w_count_dec[4*d +: 4] = 4'd9;
                end else begin
                    w_count_dec[4*d +: 4] = v_digit - 4'd1;
                    v_borrow = 1'b0;
                end
            end
            if (load_value[4*d +: 4] > 4'd9) begin
                w_load_masked[4*d +: 4] = 4'd9;
            end
        end
        w_carry_out  = v_carry;
        w_borrow_out = v_borrow;
    end
`else
    // Plain binary step; the extra MSB reports the wrap
    always_comb begin
        w_load_masked                = load_value;
        {w_carry_out,  w_count_inc}  = {1'b0, r_count} + (CW+1)'(1);
        {w_borrow_out, w_count_dec}  = {1'b0, r_count} - (CW+1)'(1);
    end
`endif

    // Divider, count and pulse registers; clear beats load beats step
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count    <= '0;
            r_tick     <= 1'b0;
            r_wrap     <= 1'b0;
            r_div_cnt  <= w_reload;
            r_rate_sel <= rate_sel;
        end else begin
            r_rate_sel <= rate_sel;
            r_tick     <= 1'b0;
            r_wrap     <= 1'b0;
            if (clear) begin
                r_count   <= '0;
                r_div_cnt <= w_reload;
            end else if (load) begin
                r_count   <= w_load_masked;
                r_div_cnt <= w_reload;
            end else begin
                if (w_rate_change) begin
                    r_div_cnt <= w_reload;
                end else if (enable) begin
                    r_div_cnt <= w_step ? w_reload : r_div_cnt - DIV_W'(1);
                end
                if (w_step) begin
                    r_count <= up_down ? w_count_inc : w_count_dec;
                    r_tick  <= 1'b1;
                    r_wrap  <= up_down ? w_carry_out : w_borrow_out;
                end
            end
        end
    end

    assign count_out = r_count;
    assign tick      = r_tick;
    assign wrap      = r_wrap;

endmodule
